// File: rtl/draw_text_overlay_if.sv
// vga_bus: pixel timing and colour passed between layers of the video chain.
interface vga_bus;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport source (output hcount, output vcount, output hsync, output vsync,
                    output hblnk, output vblnk, output rgb);
    modport sink   (input hcount, input vcount, input hsync, input vsync,
                    input hblnk, input vblnk, input rgb);
endinterface

// File: rtl/draw_text_overlay.sv
// Text overlay: draws an N_COLS x N_ROWS grid of 8x16 glyphs onto the vga_bus stream,
// with integer scaling, optional box background and vsync-counted blinking. Latency is 3 clk.

// Glyph ROM, registered one-cycle read, address {code, line}, bit 7 = leftmost pixel.
module font_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] addr_s,
    output logic [7:0]  data_r
);
    function automatic logic [7:0] lookup(input logic [10:0] a);
        logic [7:0] d;
        d = 8'h00;
        case (a[10:4])
            7'h41: begin
                case (a[3:0])
                    4'd2:                      d = 8'h10;
                    4'd3:                      d = 8'h38;
                    4'd4:                      d = 8'h6C;
                    4'd5, 4'd6:                d = 8'hC6;
                    4'd7:                      d = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11:  d = 8'hC6;
                    default:                   d = 8'h00;
                endcase
            end
            7'h7F:   d = 8'hFF;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // ROM output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= 8'h00;
        end else begin
            data_r <= lookup(addr_s);
        end
    end
endmodule

module draw_text_overlay #(
    parameter int          X_POS        = 448,
    parameter int          Y_POS        = 368,
    parameter int          N_COLS       = 16,
    parameter int          N_ROWS       = 2,
    parameter int          SCALE_LOG2   = 0,
    parameter logic [11:0] FG_COLOR     = 12'h666,
    parameter bit          BG_EN        = 1'b0,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 30,
    localparam int         N_CHARS      = N_COLS * N_ROWS,
    localparam int         AW           = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          blink_en,
    output logic [AW-1:0] char_addr,
    input  logic [6:0]    char_code,
    vga_bus.sink          bus_in,
    vga_bus.source        bus_out
);
    localparam int S = SCALE_LOG2;
    localparam logic [12:0] X_BEG = 13'(X_POS);
    localparam logic [12:0] X_END = 13'(X_POS + N_COLS * (8 << S));
    localparam logic [12:0] Y_BEG = 13'(Y_POS);
    localparam logic [12:0] Y_END = 13'(Y_POS + N_ROWS * (16 << S));
    localparam int CW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    pix_t          in_pix_s, s0_r, s1_r, out_r;
    logic          in_box_s, visible_s;
    logic [10:0]   rx_s, ry_s, col_s, row_s;
    logic [AW-1:0] lin_s;
    logic          in_box0_r, en0_r, vis0_r, in_box1_r, en1_r, vis1_r, blank1_r;
    logic [2:0]    px0_r, px1_r;
    logic [3:0]    line0_r;
    logic [7:0]    rom_data_r, font_line_s;
    logic          glyph_bit_s;
    logic [11:0]   rgb_s;
    logic          vsync_prev_r, phase_r;
    logic [CW-1:0] cnt_r;

    // Stage-0 geometry: box hit test and character/pixel coordinates
    always_comb begin
        in_pix_s = {bus_in.hcount, bus_in.vcount, bus_in.hsync, bus_in.vsync,
                    bus_in.hblnk, bus_in.vblnk, bus_in.rgb};
        in_box_s = ({2'b00, bus_in.hcount} >= X_BEG) && ({2'b00, bus_in.hcount} < X_END) &&
                   ({2'b00, bus_in.vcount} >= Y_BEG) && ({2'b00, bus_in.vcount} < Y_END);
        rx_s      = bus_in.hcount - 11'(X_POS);
        ry_s      = bus_in.vcount - 11'(Y_POS);
        col_s     = rx_s >> (3 + S);
        row_s     = ry_s >> (4 + S);
        lin_s     = AW'(row_s * 11'(N_COLS) + col_s);
        visible_s = !blink_en || !phase_r;
    end

    // Stage 0 register; char_addr holds outside the box
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_r      <= '0;
            in_box0_r <= 1'b0;
            px0_r     <= 3'd0;
            line0_r   <= 4'd0;
            en0_r     <= 1'b0;
            vis0_r    <= 1'b0;
            char_addr <= '0;
        end else begin
            s0_r      <= in_pix_s;
            in_box0_r <= in_box_s;
            px0_r     <= rx_s[S +: 3];
            line0_r   <= ry_s[S +: 4];
            en0_r     <= en;
            vis0_r    <= visible_s;
            if (in_box_s) begin
                char_addr <= lin_s;
            end else begin
                char_addr <= char_addr;
            end
        end
    end

    font_rom u_font_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_s ({char_code, line0_r}),
        .data_r (rom_data_r)
    );

    // Stage 1 register, aligned with the ROM output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r      <= '0;
            in_box1_r <= 1'b0;
            px1_r     <= 3'd0;
            en1_r     <= 1'b0;
            vis1_r    <= 1'b0;
            blank1_r  <= 1'b0;
        end else begin
            s1_r      <= s0_r;
            in_box1_r <= in_box0_r;
            px1_r     <= px0_r;
            en1_r     <= en0_r;
            vis1_r    <= vis0_r;
            blank1_r  <= (char_code == 7'd0);
        end
    end

    // Stage 2 colour select; blanking always wins
    always_comb begin
        if (blank1_r) begin
            font_line_s = 8'h00;
        end else begin
            font_line_s = rom_data_r;
        end
        glyph_bit_s = font_line_s[3'd7 - px1_r];
        if (s1_r.hblnk || s1_r.vblnk) begin
            rgb_s = s1_r.rgb;
        end else if (en1_r && in_box1_r && glyph_bit_s && vis1_r) begin
            rgb_s = FG_COLOR;
        end else if (en1_r && in_box1_r && BG_EN) begin
            rgb_s = BG_COLOR;
        end else begin
            rgb_s = s1_r.rgb;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= '0;
        end else begin
            out_r     <= s1_r;
            out_r.rgb <= rgb_s;
        end
    end

    // Blink frame counter, free-running regardless of en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_prev_r <= 1'b0;
            cnt_r        <= '0;
            phase_r      <= 1'b0;
        end else begin
            vsync_prev_r <= bus_in.vsync;
            if (bus_in.vsync && !vsync_prev_r) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r   <= '0;
                    phase_r <= !phase_r;
                end else begin
                    cnt_r   <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r   <= cnt_r;
                phase_r <= phase_r;
            end
        end
    end

    assign bus_out.hcount = out_r.hcount;
    assign bus_out.vcount = out_r.vcount;
    assign bus_out.hsync  = out_r.hsync;
    assign bus_out.vsync  = out_r.vsync;
    assign bus_out.hblnk  = out_r.hblnk;
    assign bus_out.vblnk  = out_r.vblnk;
    assign bus_out.rgb    = out_r.rgb;
endmodule

// File: tb/tb_draw_text_overlay.sv
// Bench for draw_text_overlay: two instances (defaults, and scaled/background/fast-blink)
// driven from a shared bus; table-driven pixel checks plus reset, addressing and blink sequences.
module tb_draw_text_overlay;
    logic       clk = 1'b0;
    logic       rst, en, blink_en;
    logic [4:0] addr_a, addr_b;
    logic [6:0] code_a, code_b;
    logic [6:0] buf_a [32];
    logic [6:0] buf_b [32];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    vga_bus bin ();
    vga_bus bout_a ();
    vga_bus bout_b ();

    assign code_a = buf_a[addr_a];
    assign code_b = buf_b[addr_b];

    draw_text_overlay dut_a (
        .clk(clk), .rst(rst), .en(en), .blink_en(blink_en),
        .char_addr(addr_a), .char_code(code_a), .bus_in(bin), .bus_out(bout_a)
    );

    draw_text_overlay #(.SCALE_LOG2(1), .BG_EN(1'b1), .BG_COLOR(12'h00F), .BLINK_FRAMES(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .blink_en(blink_en),
        .char_addr(addr_b), .char_code(code_b), .bus_in(bin), .bus_out(bout_b)
    );

    wire [37:0] out_a_w = {bout_a.hcount, bout_a.vcount, bout_a.hsync, bout_a.vsync,
                           bout_a.hblnk, bout_a.vblnk, bout_a.rgb};
    wire [37:0] out_b_w = {bout_b.hcount, bout_b.vcount, bout_b.hsync, bout_b.vsync,
                           bout_b.hblnk, bout_b.vblnk, bout_b.rgb};

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        en;
        logic [11:0] rgb;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [37:0] p);
        {bin.hcount, bin.vcount, bin.hsync, bin.vsync, bin.hblnk, bin.vblnk, bin.rgb} = p;
    endtask

    task automatic px(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                      input logic vs, input logic [11:0] rgb);
        drive({h, v, 1'b0, vs, hb, vb, rgb});
    endtask

    task automatic idle();
        px(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic add(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                       input logic e, input logic [11:0] rgb, input logic [11:0] ea,
                       input logic [11:0] eb);
        vec_t t;
        t.h = h; t.v = v; t.hb = hb; t.vb = vb; t.en = e; t.rgb = rgb; t.exp_a = ea; t.exp_b = eb;
        vecs.push_back(t);
    endtask

    // One isolated pixel, dut_b rgb checked exactly 3 clk later
    task automatic pix_check(input string name, input logic [10:0] h, input logic [10:0] v,
                             input logic [11:0] exp_b);
        px(h, v, 1'b0, 1'b0, 1'b0, 12'hABC);
        @(posedge clk); #1;
        idle();
        @(posedge clk);
        @(posedge clk); #1;
        check(name, {26'd0, bout_b.rgb}, {26'd0, exp_b});
    endtask

    task automatic vsync_pulse();
        px(11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 12'h000);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [37:0] cur, e0, e1, e2;
        logic [63:0] r64;
        int n;

        for (int i = 0; i < 32; i++) begin
            buf_a[i] = 7'h00;
            buf_b[i] = 7'h00;
        end
        buf_a[0] = 7'h41; buf_a[21] = 7'h7F;
        buf_b[0] = 7'h41; buf_b[1]  = 7'h7F;

        // reset state
        rst = 1'b0; en = 1'b1; blink_en = 1'b0;
        px(11'd451, 11'd370, 1'b0, 1'b0, 1'b0, 12'hFFF);
        @(posedge clk); @(posedge clk); #1;
        check("reset_out_a", out_a_w, 38'd0);
        check("reset_out_b", out_b_w, 38'd0);
        check("reset_addr", {28'd0, addr_a, addr_b}, 38'd0);
        rst = 1'b1;

        // pass-through with en=0, mid-frame reset, 3-deep reference pipeline
        en = 1'b0;
        e0 = '0; e1 = '0; e2 = '0;
        for (int c = 0; c < 400; c++) begin
            r64 = {$urandom, $urandom};
            cur = r64[37:0];
            drive(cur);
            if (c == 200) begin
                #1 rst = 1'b0;
                #1;
                check("async_reset_a", out_a_w, 38'd0);
                check("async_reset_b", out_b_w, 38'd0);
                check("async_reset_addr", {28'd0, addr_a, addr_b}, 38'd0);
            end
            if (c == 203) begin
                #1 rst = 1'b1;
            end
            @(posedge clk);
            if (!rst) begin
                e0 = '0; e1 = '0; e2 = '0;
            end else begin
                e2 = e1; e1 = e0; e0 = cur;
            end
            #1;
            check("pass_a", out_a_w, e2);
            check("pass_b", out_b_w, e2);
        end

        // table: h, v, hblnk, vblnk, en, rgb_in, expected dut_a rgb, expected dut_b rgb
        add(11'd448, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd451, 11'd370, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h666, 12'h00F);
        add(11'd452, 11'd370, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd448, 11'd373, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h666, 12'h00F);
        add(11'd455, 11'd375, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h666);
        add(11'd454, 11'd375, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h666, 12'h666);
        add(11'd455, 11'd376, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd450, 11'd376, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h666);
        add(11'd451, 11'd377, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h666);
        add(11'd456, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd460, 11'd379, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h666);
        add(11'd488, 11'd384, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h666, 12'h00F);
        add(11'd447, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'hABC);
        add(11'd576, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd575, 11'd399, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd703, 11'd431, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd704, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'hABC);
        add(11'd448, 11'd432, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'hABC);
        add(11'd448, 11'd400, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h00F);
        add(11'd472, 11'd368, 1'b0, 1'b0, 1'b1, 12'hABC, 12'hABC, 12'h666);
        add(11'd451, 11'd370, 1'b1, 1'b0, 1'b1, 12'h123, 12'h123, 12'h123);
        add(11'd472, 11'd368, 1'b0, 1'b1, 1'b1, 12'h321, 12'h321, 12'h321);
        add(11'd451, 11'd370, 1'b0, 1'b0, 1'b0, 12'h456, 12'h456, 12'h456);
        add(11'd472, 11'd368, 1'b0, 1'b0, 1'b0, 12'h456, 12'h456, 12'h456);
        add(11'd454, 11'd375, 1'b0, 1'b0, 1'b1, 12'h789, 12'h666, 12'h666);

        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                px(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, 1'b0, vecs[i].rgb);
                en = vecs[i].en;
            end else begin
                idle();
            end
            @(posedge clk); #1;
            if (i >= 2) begin
                check($sformatf("vec%0d_a", i - 2), {26'd0, bout_a.rgb}, {26'd0, vecs[i-2].exp_a});
                check($sformatf("vec%0d_b", i - 2), {26'd0, bout_b.rgb}, {26'd0, vecs[i-2].exp_b});
            end
        end

        // char_addr one clk after the pixel, held outside the box
        en = 1'b1;
        px(11'd488, 11'd384, 1'b0, 1'b0, 1'b0, 12'hABC);
        @(posedge clk); #1;
        check("addr_cell21", {28'd0, addr_a, addr_b}, {28'd0, 5'd21, 5'd2});
        px(11'd447, 11'd368, 1'b0, 1'b0, 1'b0, 12'hABC);
        @(posedge clk); #1;
        check("addr_hold_left", {28'd0, addr_a, addr_b}, {28'd0, 5'd21, 5'd2});
        px(11'd576, 11'd368, 1'b0, 1'b0, 1'b0, 12'hABC);
        @(posedge clk); #1;
        check("addr_hold_right", {28'd0, addr_a, addr_b}, {28'd0, 5'd21, 5'd8});
        idle();

        // blink: BLINK_FRAMES=2 on dut_b, phase restarts at 0 after reset
        do_reset();
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            pix_check($sformatf("blink_glyph_f%0d", f), 11'd472, 11'd368,
                      ((f / 2) % 2 == 1) ? 12'h00F : 12'h666);
            pix_check($sformatf("blink_bg_f%0d", f), 11'd488, 11'd368, 12'h00F);
            vsync_pulse();
        end
        // phase is now 1: blink_en=0 keeps glyphs visible
        blink_en = 1'b0;
        pix_check("noblink_a", 11'd472, 11'd368, 12'h666);
        blink_en = 1'b1;
        pix_check("blink_hidden_again", 11'd472, 11'd368, 12'h00F);
        // counter keeps running with en=0
        en = 1'b0;
        vsync_pulse();
        vsync_pulse();
        en = 1'b1;
        pix_check("blink_resume_phase", 11'd472, 11'd368, 12'h666);
        blink_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/draw_text_overlay.md
Name: draw_text_overlay

Overview:
- Parametrised successor to the hard-coded menu text drawer: overlays a grid of 8x16 font glyphs, N_COLS x N_ROWS characters, onto the vga_bus pixel stream.
- Character codes come from an external text buffer through a 1-cycle read port. Glyph bitmaps come from the team font_rom: 128 glyphs x 16 lines x 8 bits, registered 1-cycle read, address {code[6:0], line[3:0]}, bit 7 = leftmost pixel.
- Adds integer pixel scaling, optional background fill and frame-counted blinking.
- Sits in the vga_bus chain between the background/game layers and the VGA output register.

Parameters:
X_POS, 448, hcount of box left edge
Y_POS, 368, vcount of box top edge
N_COLS, 16, characters per text row (1..64)
N_ROWS, 2, text rows (1..16)
SCALE_LOG2, 0, glyph magnification 2**SCALE_LOG2 (0..2)
FG_COLOR, 12'h666, glyph pixel colour
BG_EN, 0, 1 = paint non-glyph box pixels with BG_COLOR
BG_COLOR, 12'h000, box background colour
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-low
en  in  1  overlay enable, 0 = pure pass-through
blink_en  in  1  1 = text blinks
char_addr  out  $clog2(N_COLS*N_ROWS)  text buffer address, row*N_COLS+col
char_code  in  7  buffer data, valid 1 clk after char_addr
bus_in  vga_bus  -  input timing/rgb
bus_out  vga_bus  -  output timing/rgb

Behaviour:
- Reset (rst=0, async): all bus_out fields 0, char_addr 0, frame counter 0, blink phase 0, all pipeline registers 0.
- Latency: fixed 3 clk for every bus field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb). bus_out.X(t) = f(bus_in.X(t-3)). The bench checks alignment exactly.
- Stage 0 (registered):
  - in_box = hcount in [X_POS, X_POS+N_COLS*(8<<S)) and vcount in [Y_POS, Y_POS+N_ROWS*(16<<S)), where S = SCALE_LOG2.
  - rx = hcount-X_POS, ry = vcount-Y_POS, computed in 11 bits.
  - col = rx>>(3+S); row = ry>>(4+S); px = (rx>>S)&7; line = (ry>>S)&15.
  - char_addr <= row*N_COLS+col when in_box, else it holds its value.
  - Register in_box, px, line, en and blink-visible alongside the bus fields.
- Stage 1: char_code arrives; font_rom addressed with {char_code, line}. Code 0 is forced blank: treat the glyph line as 8'h00.
- Stage 2:
  - glyph_bit = font_line[7-px].
  - Output rgb, in priority order:
    1. If hblnk or vblnk, pass-through.
    2. Else if en and in_box and glyph_bit and visible, FG_COLOR.
    3. Else if en and in_box and BG_EN, BG_COLOR.
    4. Else bus_in rgb as delayed.
- Blink:
  - Frame counter (width $clog2(BLINK_FRAMES)+1) increments on each rising edge of bus_in.vsync (edge detected against registered previous vsync).
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles phase.
  - visible = !blink_en or phase==0. Only glyph pixels are affected; the background stays drawn.
  - The counter runs while en=0, so blinking resumes in phase.
- en and blink_en are sampled at stage 0 per pixel. A mid-frame toggle takes effect exactly 3 clk later at pixel granularity; no frame-boundary qualification.
- Box edge beyond the visible area: pixels outside the visible area simply never occur. No wrap, no clamping. in_box is false when hcount < X_POS (no unsigned underflow match).
- Reset deassertion mid-frame: output stays 0 for 3 clk while the pipeline fills, then tracks bus_in normally. The blink phase restarts at 0.

Test Plan:
- Pass-through: en=0, random bus_in for 2 frames -> bus_out equals bus_in delayed exactly 3 clk on all fields. Reset mid-frame -> all outputs 0 immediately, and resume 3 clk after release.
- Glyph draw, defaults: buffer[0]=0x41, buffer[1]=0x00. For hcount 448..455 and vcount 368..383 -> rgb_out=12'h666 iff font_rom[0x41*16+(v-368)][7-(h-448)], else bus_in rgb. Cells 456..463 -> never FG.
- Addressing: N_COLS=16, N_ROWS=2, pixel (h=448+8*5, v=368+16) -> char_addr=21 one clk later. Pixel (447,368) and (576,368) -> char_addr unchanged, rgb pass-through.
- Scaling: SCALE_LOG2=1 -> each glyph bit covers a 2x2 pixel block. Pixel (448+2*3+1, 368+2*4) uses px=3, line=4, col=0. Box right edge at 448+256 exclusive.
- Background: BG_EN=1, BG_COLOR=12'h00F, glyph 0x00 everywhere -> the whole box area is 12'h00F. During hblnk, bus_in rgb passes unchanged.
- Blink: BLINK_FRAMES=2, blink_en=1, 6 vsync pulses -> glyph pixels visible in frames 0-1, hidden in 2-3, visible in 4-5, with background unaffected. blink_en=0 -> always visible.
